// File: rtl/mesi_isc_breq_arb.sv
// mesi_isc_breq_arb: round-robin arbiter that forwards per-CPU bus requests
// into a single-entry broadcast holding register with a wrapping sequence tag.
module mesi_isc_breq_arb #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    breq_valid_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
  input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
  output logic [3:0]                    breq_pop_o,
  input  logic                          broad_fifo_full_i,
  output logic                          broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [ADDR_WIDTH-1:0]         broad_addr_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
  output logic                          err_illegal_o
);
  typedef enum logic [1:0] {EMPTY, LOADED, STALLED} state_e;
  state_e                        state_q, state_d;
  logic [1:0]                    rr_q, gnt_idx, cpu_q;
  logic [BROAD_TYPE_WIDTH-1:0]   typ, type_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [BROAD_ID_WIDTH-1:0]     id_q, cnt_q;
  logic                          err_q, gnt_any, out_valid, en, fire, fwd, ill;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    for (int k = 3; k >= 0; k--)
      if (breq_valid_i[rr_q + 2'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_q + 2'(k);
      end
  end
  assign out_valid = state_q != EMPTY;
  // a held entry that transfers this cycle frees the register for a new grant
  assign en   = !out_valid || !broad_fifo_full_i;
  assign fire = en && gnt_any;
  assign typ  = breq_type_array_i[BROAD_TYPE_WIDTH*gnt_idx +: BROAD_TYPE_WIDTH];
  assign fwd  = fire && (typ == BROAD_TYPE_WIDTH'(1) || typ == BROAD_TYPE_WIDTH'(2));
  assign ill  = fire && typ == BROAD_TYPE_WIDTH'(3);
  assign state_d = fwd ? LOADED : (out_valid && broad_fifo_full_i) ? STALLED : EMPTY;
  assign breq_pop_o = (fire && !rst) ? 4'b0001 << gnt_idx : 4'b0000;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      type_q  <= '0;
      addr_q  <= '0;
      cpu_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) rr_q <= gnt_idx + 2'd1;
      if (fwd) begin
        type_q <= typ;
        addr_q <= breq_addr_array_i[ADDR_WIDTH*gnt_idx +: ADDR_WIDTH];
        cpu_q  <= gnt_idx;
        id_q   <= cnt_q;
        cnt_q  <= cnt_q + BROAD_ID_WIDTH'(1);
      end
      if (ill) err_q <= 1'b1;
    end
  end
  assign broad_fifo_wr_o = out_valid;
  assign broad_type_o    = type_q;
  assign broad_addr_o    = addr_q;
  assign broad_cpu_id_o  = cpu_q;
  assign broad_id_o      = id_q;
  assign err_illegal_o   = err_q;
endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// tb_mesi_isc_breq_arb: randomized scoreboard bench for mesi_isc_breq_arb
module tb_mesi_isc_breq_arb;
  logic         clk = 1'b0, rst = 1'b1;
  logic [3:0]   valid = '0, pop;
  logic [7:0]   types = '0;
  logic [127:0] addrs = '0;
  logic         full = 1'b0, wr, err;
  logic [1:0]   btype, bcpu;
  logic [31:0]  baddr;
  logic [4:0]   bid;
  typedef struct packed {logic [1:0] t; logic [31:0] a; logic [1:0] c; logic [4:0] id;} ent_t;
  ent_t q[$];
  int   pass_cnt = 0, tot_cnt = 0;
  int   rr = 0, cnt = 0;
  logic occ = 1'b0, err_m = 1'b0;

  mesi_isc_breq_arb dut (
    .clk(clk), .rst(rst), .breq_valid_i(valid), .breq_type_array_i(types),
    .breq_addr_array_i(addrs), .breq_pop_o(pop), .broad_fifo_full_i(full),
    .broad_fifo_wr_o(wr), .broad_type_o(btype), .broad_addr_o(baddr),
    .broad_cpu_id_o(bcpu), .broad_id_o(bid), .err_illegal_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one cycle of stimulus; the reference model decides the grant by a plain
  // modular search from the round-robin pointer and queues forwarded entries
  task automatic step(input logic [3:0] v, input logic [7:0] ty, input logic [127:0] ad, input logic f);
    int g;
    ent_t e;
    logic [1:0] t;
    @(posedge clk); #1;
    check("wr", wr, occ);
    check("err", err, err_m);
    valid = v; types = ty; addrs = ad; full = f;
    #1;
    g = -1;
    if (!occ || !f)
      for (int k = 0; k < 4; k++) if (g < 0 && v[(rr + k) % 4]) g = (rr + k) % 4;
    check("pop", pop, g < 0 ? 64'd0 : 64'd1 << g);
    if (g >= 0) begin
      rr = (g + 1) % 4;
      t = ty[2*g +: 2];
      if (t == 2'd1 || t == 2'd2) begin
        e.t = t; e.a = ad[32*g +: 32]; e.c = 2'(g); e.id = 5'(cnt);
        q.push_back(e);
        cnt = (cnt + 1) % 32;
        occ = 1'b1;
      end else begin
        if (t == 2'd3) err_m = 1'b1;
        occ = 1'b0;
      end
    end else occ = occ && f;
  endtask

  function automatic logic [1:0] rtype();
    return ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
  endfunction

  function automatic logic [127:0] raddr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr"}, wr, 0);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_type"}, btype, 0);
    check({tag, "_addr"}, baddr, 0);
    check({tag, "_cpu"}, bcpu, 0);
    check({tag, "_id"}, bid, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // monitor: every transfer must match the oldest queued expectation
  initial forever begin
    ent_t e;
    @(negedge clk);
    if (!rst && wr && !full) begin
      if (q.size() == 0) begin
        tot_cnt++;
        $display("FAIL xfer: got transfer id %0h expected none queued", bid);
      end else begin
        e = q.pop_front();
        check("xfer_type", btype, e.t);
        check("xfer_addr", baddr, e.a);
        check("xfer_cpu", bcpu, e.c);
        check("xfer_id", bid, e.id);
      end
    end
  end

  initial begin
    logic [7:0] ty;
    valid = 4'hf; types = 8'h55; addrs = raddr();
    #3;
    check_zero_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    valid = '0; rst = 1'b0;
    for (int i = 0; i < 5; i++) step(4'hf, 8'haa, raddr(), 1'b0);
    step(4'b0100, 8'h10, {32'h0, 32'h55, 64'h0}, 1'b0);
    step(4'b0000, 8'h00, '0, 1'b0);
    step(4'b0001, 8'h03, raddr(), 1'b0);
    step(4'b0001, 8'h00, raddr(), 1'b0);
    step(4'b0000, 8'h00, '0, 1'b0);
    for (int i = 0; i < 40; i++) step(4'b0010, 8'h04, raddr(), 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 8'h04, raddr(), 1'b1);
    step(4'b0010, 8'h04, raddr(), 1'b0);
    for (int blk = 0; blk < 5; blk++)
      for (int i = 0; i < 300; i++) begin
        for (int c = 0; c < 4; c++) ty[2*c +: 2] = rtype();
        step(4'($urandom), ty, raddr(), $urandom_range(0, 4) < blk);
      end
    for (int i = 0; i < 3; i++) step(4'b0000, 8'h00, '0, 1'b0);
    step(4'b0010, 8'h04, raddr(), 1'b1);
    step(4'b0010, 8'h04, raddr(), 1'b1);
    @(posedge clk); #1;
    check("wr_pre_rst", wr, occ);
    rst = 1'b1;
    #1;
    check("rst_wr", wr, 0);
    check("rst_pop", pop, 0);
    check("rst_id", bid, 0);
    check("rst_addr", baddr, 0);
    q.delete();
    occ = 1'b0; rr = 0; cnt = 0; err_m = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    valid = '0; rst = 1'b0;
    step(4'hf, 8'h55, raddr(), 1'b0);
    check("first_after_rst", pop, 4'b0001);
    for (int i = 0; i < 3; i++) step(4'b0000, 8'h00, '0, 1'b0);
    @(negedge clk); #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mesi_isc_breq_arb.md
MESI_ISC_BREQ_ARB -- requirements
Module: mesi_isc_breq_arb

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_WIDTH, default 32, request address width.
- BROAD_TYPE_WIDTH, default 2, request type width.
- BROAD_ID_WIDTH, default 5, broadcast sequence tag width.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- breq_valid_i  in  4  per-CPU request pending; bit n belongs to CPU n.
- breq_type_array_i  in  8  2-bit type per CPU, CPU n at [2n+1:2n]: 0 NOP, 1 WR, 2 RD, 3 illegal.
- breq_addr_array_i  in  4*ADDR_WIDTH  address per CPU, CPU n at [ADDR_WIDTH*(n+1)-1:ADDR_WIDTH*n].
- breq_pop_o  out  4  one-hot0 pop strobe to the per-CPU request FIFOs.
- broad_fifo_full_i  in  1  broadcast FIFO cannot accept a write this cycle.
- broad_fifo_wr_o  out  1  broadcast entry valid.
- broad_type_o  out  2  forwarded type.
- broad_addr_o  out  ADDR_WIDTH  forwarded address.
- broad_cpu_id_o  out  2  originating CPU.
- broad_id_o  out  BROAD_ID_WIDTH  sequence tag.
- err_illegal_o  out  1  sticky: an illegal type was popped.

Function
REQ-003 Output stage SHALL be a single holding register (out_valid); broad_fifo_wr_o equals out_valid.
REQ-004 A transfer SHALL occur in a cycle where broad_fifo_wr_o=1 and broad_fifo_full_i=0.
REQ-005 While broad_fifo_wr_o=1 and broad_fifo_full_i=1, all broad_* outputs SHALL hold stable.
REQ-006 Arbitration SHALL be enabled in a cycle iff out_valid=0 or a transfer occurs that cycle (zero-bubble back-to-back).
REQ-007 When enabled, the grant SHALL go to the first CPU with breq_valid_i=1, searching rr_ptr, rr_ptr+1, ... modulo 4.
REQ-008 breq_pop_o SHALL be combinational and SHALL assert only the granted bit.
REQ-009 breq_pop_o SHALL be 0 when arbitration is disabled or no request is valid.
REQ-010 After each grant, rr_ptr (2 bits) SHALL load granted+1, wrapping 3->0; with no grant, rr_ptr SHALL hold.
REQ-011 A granted WR or RD SHALL load the holding register on the next edge:
- type, address and CPU id from the granted CPU;
- broad_id_o = id_cnt.
- id_cnt SHALL then increment, wrapping 31->0.
REQ-012 A granted NOP or illegal type SHALL be popped (discarded):
- no output load; id_cnt unchanged; rr_ptr still advances.
- illegal type SHALL additionally set err_illegal_o, which stays set until reset.
REQ-013 If a transfer occurs and nothing new is loaded in the same cycle, out_valid SHALL clear on the next edge.
REQ-014 Latency SHALL be 1 cycle from pop to broad_fifo_wr_o=1; sustained throughput SHALL be 1 entry/cycle while the FIFO is not full.
REQ-015 Internal FSM states SHALL be:
- EMPTY (out_valid=0)
- LOADED (out_valid=1, not stalled)
- STALLED (out_valid=1, full=1)
REQ-016 FSM transitions SHALL be:
- EMPTY->LOADED on a forwarding grant.
- LOADED->STALLED on full.
- STALLED->LOADED on not full with a new grant.
- LOADED/STALLED->EMPTY on transfer with no new grant.
REQ-017 breq_valid_i changing during a stall SHALL NOT affect the held entry.

Reset
REQ-018 On rst=1, asynchronously:
- out_valid=0, so broad_fifo_wr_o=0;
- broad_type_o=0, broad_addr_o=0, broad_cpu_id_o=0, broad_id_o=0;
- rr_ptr=0, id_cnt=0, err_illegal_o=0.
REQ-019 During reset, breq_pop_o SHALL be 0.
REQ-020 Reset asserted mid-stall SHALL drop the held entry; no pop is replayed.
REQ-021 The first grant after reset release SHALL favour CPU0.

Verification
REQ-022 Single request:
- Stimulus: CPU2 valid, type WR, addr 0x55, full=0.
- Required: pop=0100 in cycle 0; next cycle wr=1, type=1, addr=0x55, cpu=2, id=0; rr_ptr=3.
REQ-023 Fairness:
- Stimulus: all four valid continuously with RD, full=0.
- Required: pops 0001, 0010, 0100, 1000, 0001; ids 0,1,2,3,4.
REQ-024 Backpressure:
- Stimulus: full=1 for 3 cycles while an entry is held, CPU1 valid.
- Required: outputs stable and pop=0 for those 3 cycles; the cycle full drops, pop=0010 and the entry transfers.
REQ-025 Discard:
- Stimulus: CPU0 type 3 then CPU0 type 0.
- Required: both popped; wr stays 0; err_illegal_o=1 from the cycle after the first pop; id_cnt stays 0.
REQ-026 Wrap:
- Stimulus: 33 forwarded requests.
- Required: broad_id_o runs 0..31, then 0.
REQ-027 Reset mid-stall:
- Stimulus: assert rst while wr=1 and full=1.
- Required: wr=0 immediately; after release, the CPU0 request is granted first.
